// File: rtl/mcs4_pkg.sv
// mcs4_pkg -- constants and types shared by the i4003 shift-register loader.
//   SR_STAGE_W : bits per cascaded i4003 stage
//   NUM_SR_MAX : largest supported number of cascaded stages
//   sr_state_t : loader FSM state encoding
package mcs4_pkg;

    localparam int SR_STAGE_W = 10;
    localparam int NUM_SR_MAX = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } sr_state_t;

endpackage

// File: rtl/sr_cp_timer.sv
// sr_cp_timer -- half-period timer for the i4003 shift clock.
//   cp     : clock (rising edge)
//   reset  : synchronous, active-low
//   start  : high in the first cycle of a new sr_cp half-period
//   expire : high in the last cycle of the half-period (CP_DIV cycles
//            after start, counting the start cycle itself)
module sr_cp_timer #(
    parameter int CP_DIV = 2
) (
    input  logic cp,
    input  logic reset,
    input  logic start,
    output logic expire
);

    localparam int CW = (CP_DIV < 2) ? 1 : $clog2(CP_DIV);
    localparam logic [CW-1:0] LAST = CW'(CP_DIV - 1);

    // cnt_reg holds the index of the current cycle within the half-period;
    // the start cycle is index 0, so the counter restarts at 1.
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge cp) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (start) begin
            cnt_reg <= CW'(1);
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // With CP_DIV=1 every half-period is a single cycle, so the start cycle
    // is also the expiry cycle.
    assign expire = start ? (LAST == '0) : (cnt_reg == LAST);

endmodule

// File: rtl/sr_loader.sv
// sr_loader -- serialises a parallel word into a chain of cascaded i4003
// shift registers, MSB first, then raises the parallel-output enable.
//   cp        : clock (rising edge)
//   reset     : synchronous, active-low
//   in_data   : W-bit word to load (W = 10*NUM_SR)
//   in_valid  : in_data valid
//   in_ready  : loader idle; word accepted on in_valid && in_ready
//   sr_cp     : shift clock to the i4003 cp pin
//   sr_data   : serial data to the i4003 data pin
//   sr_e      : parallel-output enable to the i4003 e pin
//   sr_sin    : s_out of the last i4003 in the chain (readback)
//   done      : one-cycle pulse when the transfer is complete
//   rb_data   : bits shifted out of the chain during the last transfer
//   rb_valid  : rb_data valid, pulses with done
// Build option: define SR_LOADER_READBACK_EN to capture sr_sin into rb_data;
// otherwise rb_data/rb_valid are tied to 0 and sr_sin is ignored.
module sr_loader
    import mcs4_pkg::*;
#(
    parameter int NUM_SR = 1,
    parameter int CP_DIV = 2,
    localparam int W     = SR_STAGE_W * NUM_SR
) (
    input  logic         cp,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         sr_cp,
    output logic         sr_data,
    output logic         sr_e,
    input  logic         sr_sin,
    output logic         done,
    output logic [W-1:0] rb_data,
    output logic         rb_valid
);

    localparam int CNT_W = $clog2(W + 1);

    sr_state_t       state_reg;
    logic [W-1:0]    shift_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic            sr_cp_reg;
    logic            sr_data_reg;
    logic            sr_e_reg;
    logic            done_reg;
    logic            start_reg;
    logic            expire;

`ifdef SR_LOADER_READBACK_EN
    logic [W-1:0]    rb_data_reg;
    logic            rb_valid_reg;
`endif

    sr_cp_timer #(
        .CP_DIV(CP_DIV)
    ) u_timer (
        .cp    (cp),
        .reset (reset),
        .start (start_reg),
        .expire(expire)
    );

    always_ff @(posedge cp) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            sr_cp_reg   <= 1'b0;
            sr_data_reg <= 1'b0;
            sr_e_reg    <= 1'b0;
            done_reg    <= 1'b0;
            start_reg   <= 1'b0;
`ifdef SR_LOADER_READBACK_EN
            rb_data_reg  <= '0;
            rb_valid_reg <= 1'b0;
`endif
        end else begin
            start_reg <= 1'b0;
            done_reg  <= 1'b0;
`ifdef SR_LOADER_READBACK_EN
            rb_valid_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // First bit goes straight onto sr_data; shift_reg
                        // keeps the remaining bits left-aligned.
                        sr_data_reg <= in_data[W-1];
                        shift_reg   <= {in_data[W-2:0], 1'b0};
                        bit_cnt_reg <= CNT_W'(W);
                        sr_e_reg    <= 1'b0;
                        sr_cp_reg   <= 1'b0;
                        start_reg   <= 1'b1;
                        state_reg   <= LOW;
                    end
                end
                LOW: begin
                    if (expire) begin
                        sr_cp_reg <= 1'b1;
                        start_reg <= 1'b1;
                        state_reg <= HIGH;
`ifdef SR_LOADER_READBACK_EN
                        // The chain has not shifted yet on this edge, so
                        // sr_sin still shows the bit about to fall out.
                        rb_data_reg <= {rb_data_reg[W-2:0], sr_sin};
`endif
                    end
                end
                HIGH: begin
                    if (expire) begin
                        sr_cp_reg <= 1'b0;
                        if (bit_cnt_reg != CNT_W'(1)) begin
                            // sr_data moves together with the falling sr_cp,
                            // so it is never seen changing while sr_cp=1.
                            bit_cnt_reg <= bit_cnt_reg - CNT_W'(1);
                            sr_data_reg <= shift_reg[W-1];
                            shift_reg   <= {shift_reg[W-2:0], 1'b0};
                            start_reg   <= 1'b1;
                            state_reg   <= LOW;
                        end else begin
                            bit_cnt_reg <= '0;
                            sr_data_reg <= 1'b0;
                            sr_e_reg    <= 1'b1;
                            done_reg    <= 1'b1;
                            state_reg   <= DONE;
`ifdef SR_LOADER_READBACK_EN
                            rb_valid_reg <= 1'b1;
`endif
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state_reg == IDLE);
    assign sr_cp    = sr_cp_reg;
    assign sr_data  = sr_data_reg;
    assign sr_e     = sr_e_reg;
    assign done     = done_reg;

`ifdef SR_LOADER_READBACK_EN
    assign rb_data  = rb_data_reg;
    assign rb_valid = rb_valid_reg;
`else
    logic unused_sr_sin;
    assign unused_sr_sin = sr_sin;
    assign rb_data       = '0;
    assign rb_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_sr_loader.sv
// tb_sr_loader -- randomized self-checking bench for sr_loader.
// Two instances share one clock: u_a (NUM_SR=1, CP_DIV=2) and
// u_b (NUM_SR=2, CP_DIV=1); 'sel' picks which one a scenario drives.
// Each instance's chain is modelled as a plain i4003 shift register
// clocked by sr_cp whose s_out feeds sr_sin.
module tb_sr_loader;

`ifdef SR_LOADER_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        tb_valid;
    logic [19:0] tb_data;

    logic        a_in_valid, a_in_ready, a_sr_cp, a_sr_data, a_sr_e, a_sr_sin, a_done, a_rb_valid;
    logic [9:0]  a_in_data, a_rb_data;
    logic        b_in_valid, b_in_ready, b_sr_cp, b_sr_data, b_sr_e, b_sr_sin, b_done, b_rb_valid;
    logic [19:0] b_in_data, b_rb_data;

    logic        pl_stb;
    logic [19:0] pl_val;
    logic [9:0]  a_chain;
    logic [19:0] b_chain;

    logic        m_ready, m_cp, m_data, m_e, m_done, m_rbv;
    logic [19:0] m_rb, m_chain;

    int checks   = 0;
    int failures = 0;

    assign a_in_valid = tb_valid & ~sel;
    assign b_in_valid = tb_valid & sel;
    assign a_in_data  = tb_data[9:0];
    assign b_in_data  = tb_data;

    sr_loader #(.NUM_SR(1), .CP_DIV(2)) u_a (
        .cp(clk), .reset(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sr_cp(a_sr_cp), .sr_data(a_sr_data), .sr_e(a_sr_e),
        .sr_sin(a_sr_sin), .done(a_done), .rb_data(a_rb_data), .rb_valid(a_rb_valid)
    );

    sr_loader #(.NUM_SR(2), .CP_DIV(1)) u_b (
        .cp(clk), .reset(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sr_cp(b_sr_cp), .sr_data(b_sr_data), .sr_e(b_sr_e),
        .sr_sin(b_sr_sin), .done(b_done), .rb_data(b_rb_data), .rb_valid(b_rb_valid)
    );

    // i4003 chain models: shift on rising sr_cp, s_out is the oldest bit.
    always @(posedge a_sr_cp or posedge pl_stb)
        if (pl_stb) a_chain <= pl_val[9:0];
        else        a_chain <= {a_chain[8:0], a_sr_data};

    always @(posedge b_sr_cp or posedge pl_stb)
        if (pl_stb) b_chain <= pl_val;
        else        b_chain <= {b_chain[18:0], b_sr_data};

    assign a_sr_sin = a_chain[9];
    assign b_sr_sin = b_chain[19];

    assign m_ready = sel ? b_in_ready : a_in_ready;
    assign m_cp    = sel ? b_sr_cp    : a_sr_cp;
    assign m_data  = sel ? b_sr_data  : a_sr_data;
    assign m_e     = sel ? b_sr_e     : a_sr_e;
    assign m_done  = sel ? b_done     : a_done;
    assign m_rbv   = sel ? b_rb_valid : a_rb_valid;
    assign m_rb    = sel ? b_rb_data  : {10'b0, a_rb_data};
    assign m_chain = sel ? b_chain    : {10'b0, a_chain};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [19:0] v);
        pl_val = v;
        pl_stb = 1'b1;
        #1;
        pl_stb = 1'b0;
    endtask

    // Runs one transfer on the selected instance and reports what was seen.
    // Called just after a falling edge. Cycle k is the k-th clock period
    // after the acceptance edge; 'bad' counts sr_data changing while sr_cp=1
    // and any pre-done cycle with sr_e, rb_valid or in_ready high.
    task automatic xfer(input logic [19:0] word, input bit hold, input int poke,
                        output logic [19:0] bits, output int rises, output int done_at,
                        output int bad, output logic ready0, output logic poke_ready,
                        output logic [19:0] rb, output logic rbv,
                        output logic cp_d, output logic data_d, output logic e_d);
        logic prev_cp, prev_data;
        bits = '0; rises = 0; done_at = -1; bad = 0; poke_ready = 1'bx;
        rb = 'x; rbv = 1'bx; cp_d = 1'bx; data_d = 1'bx; e_d = 1'bx;
        ready0    = m_ready;
        prev_cp   = m_cp;
        prev_data = m_data;
        tb_data   = word;
        tb_valid  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tb_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == poke) begin
                poke_ready = m_ready;
                tb_valid   = 1'b1;
                tb_data    = ~word;
            end else if (poke != 0 && k == poke + 1) begin
                tb_valid = 1'b0;
                tb_data  = word;
            end
            if (m_cp === 1'b1 && prev_cp === 1'b0) begin
                rises++;
                bits = {bits[18:0], m_data};
            end
            if (m_data !== prev_data && m_cp !== 1'b0) bad++;
            if (m_done === 1'b1) begin
                done_at = k; rb = m_rb; rbv = m_rbv; cp_d = m_cp; data_d = m_data; e_d = m_e;
                break;
            end
            if (m_e !== 1'b0 || m_rbv !== 1'b0 || m_ready !== 1'b0) bad++;
            prev_cp   = m_cp;
            prev_data = m_data;
        end
        $display("xfer sel=%0d word=%05h bits=%05h rises=%0d done_at=%0d rb=%05h", sel, word, bits, rises, done_at, rb);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tb_valid = 1'b0; tb_data = '0; sel = 1'b0; pl_stb = 1'b0; pl_val = '0;
        preload(20'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_a_ready got=%b exp=1", a_in_ready); end
        checks++; if ({a_sr_cp, a_sr_data, a_sr_e, a_done, a_rb_valid} !== 5'b0) begin failures++; $display("FAIL reset_a_outs got=%b exp=00000", {a_sr_cp, a_sr_data, a_sr_e, a_done, a_rb_valid}); end
        checks++; if (a_rb_data !== 10'h0) begin failures++; $display("FAIL reset_a_rb got=%h exp=0", a_rb_data); end
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_b_ready got=%b exp=1", b_in_ready); end
        checks++; if ({b_sr_cp, b_sr_data, b_sr_e, b_done, b_rb_valid} !== 5'b0) begin failures++; $display("FAIL reset_b_outs got=%b exp=00000", {b_sr_cp, b_sr_data, b_sr_e, b_done, b_rb_valid}); end
        checks++; if (b_rb_data !== 20'h0) begin failures++; $display("FAIL reset_b_rb got=%h exp=0", b_rb_data); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [19:0] bits, rb; int rises, done_at, bad; logic r0, pr, rbv, cpd, dd, ed;
        sel = 1'b0;
        preload(20'h003C1);
        xfer(20'h002A5, 1'b0, 0, bits, rises, done_at, bad, r0, pr, rb, rbv, cpd, dd, ed);
        checks++; if (r0 !== 1'b1) begin failures++; $display("FAIL dir_ready got=%b exp=1", r0); end
        checks++; if (bits !== 20'h002A5) begin failures++; $display("FAIL dir_bits got=%h exp=002a5", bits); end
        checks++; if (rises !== 10) begin failures++; $display("FAIL dir_rises got=%0d exp=10", rises); end
        checks++; if (done_at !== 41) begin failures++; $display("FAIL dir_done_at got=%0d exp=41", done_at); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL dir_protocol got=%0d exp=0", bad); end
        checks++; if ({cpd, dd, ed} !== 3'b001) begin failures++; $display("FAIL dir_done_outs got=%b exp=001", {cpd, dd, ed}); end
        checks++; if (rb !== (RB_EN ? 20'h003C1 : 20'h0)) begin failures++; $display("FAIL dir_rb got=%h exp=%h", rb, RB_EN ? 20'h003C1 : 20'h0); end
        checks++; if (rbv !== RB_EN) begin failures++; $display("FAIL dir_rbv got=%b exp=%b", rbv, RB_EN); end
        checks++; if (m_chain !== 20'h002A5) begin failures++; $display("FAIL dir_chain got=%h exp=002a5", m_chain); end
        @(negedge clk);
        checks++; if ({m_done, m_rbv, m_e, m_ready} !== 4'b0011) begin failures++; $display("FAIL dir_after got=%b exp=0011", {m_done, m_rbv, m_e, m_ready}); end
        checks++; if (m_rb !== (RB_EN ? 20'h003C1 : 20'h0)) begin failures++; $display("FAIL dir_rb_hold got=%h exp=%h", m_rb, RB_EN ? 20'h003C1 : 20'h0); end
        repeat (3) @(negedge clk);
        checks++; if (m_e !== 1'b1) begin failures++; $display("FAIL dir_e_hold got=%b exp=1", m_e); end
    endtask

    task automatic test_random;
        logic [19:0] bits, rb, word, pre, mask; int rises, done_at, bad, w, cpdiv; logic r0, pr, rbv, cpd, dd, ed;
        for (int i = 0; i < 8; i++) begin
            sel   = 1'($urandom_range(0, 1));
            mask  = sel ? 20'hFFFFF : 20'h003FF;
            w     = sel ? 20 : 10;
            cpdiv = sel ? 1 : 2;
            word  = 20'($urandom) & mask;
            pre   = 20'($urandom) & mask;
            preload(pre);
            xfer(word, 1'b0, 0, bits, rises, done_at, bad, r0, pr, rb, rbv, cpd, dd, ed);
            checks++; if (bits !== word) begin failures++; $display("FAIL rnd_bits got=%h exp=%h", bits, word); end
            checks++; if (rises !== w) begin failures++; $display("FAIL rnd_rises got=%0d exp=%0d", rises, w); end
            checks++; if (done_at !== 2 * cpdiv * w + 1) begin failures++; $display("FAIL rnd_done_at got=%0d exp=%0d", done_at, 2 * cpdiv * w + 1); end
            checks++; if (bad !== 0) begin failures++; $display("FAIL rnd_protocol got=%0d exp=0", bad); end
            checks++; if (rb !== (RB_EN ? pre : 20'h0)) begin failures++; $display("FAIL rnd_rb got=%h exp=%h", rb, RB_EN ? pre : 20'h0); end
            checks++; if (rbv !== RB_EN) begin failures++; $display("FAIL rnd_rbv got=%b exp=%b", rbv, RB_EN); end
            checks++; if (m_chain !== word) begin failures++; $display("FAIL rnd_chain got=%h exp=%h", m_chain, word); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_valid;
        logic [19:0] bits, rb, word; int rises, done_at, bad, poke; logic r0, pr, rbv, cpd, dd, ed;
        sel  = 1'b0;
        word = 20'($urandom) & 20'h003FF;
        // First HIGH cycle of a randomly chosen bit (CP_DIV=2: 4 cycles/bit).
        poke = 4 * $urandom_range(0, 9) + 3;
        preload(20'h0);
        xfer(word, 1'b0, poke, bits, rises, done_at, bad, r0, pr, rb, rbv, cpd, dd, ed);
        checks++; if (pr !== 1'b0) begin failures++; $display("FAIL ign_ready got=%b exp=0", pr); end
        checks++; if (bits !== word) begin failures++; $display("FAIL ign_bits got=%h exp=%h", bits, word); end
        checks++; if (rises !== 10) begin failures++; $display("FAIL ign_rises got=%0d exp=10", rises); end
        checks++; if (done_at !== 41) begin failures++; $display("FAIL ign_done_at got=%0d exp=41", done_at); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL ign_protocol got=%0d exp=0", bad); end
        repeat (2) @(negedge clk);
        checks++; if ({m_e, m_ready} !== 2'b11) begin failures++; $display("FAIL ign_idle got=%b exp=11", {m_e, m_ready}); end
    endtask

    task automatic test_back_to_back;
        logic [19:0] bits, rb; int rises, done_at, bad; logic r0, pr, rbv, cpd, dd, ed;
        sel = 1'b1;
        preload(20'h0);
        xfer(20'hFFFFF, 1'b1, 0, bits, rises, done_at, bad, r0, pr, rb, rbv, cpd, dd, ed);
        checks++; if (bits !== 20'hFFFFF) begin failures++; $display("FAIL b2b1_bits got=%h exp=fffff", bits); end
        checks++; if (rises !== 20) begin failures++; $display("FAIL b2b1_rises got=%0d exp=20", rises); end
        checks++; if (done_at !== 41) begin failures++; $display("FAIL b2b1_done_at got=%0d exp=41", done_at); end
        // in_valid stays high through the done cycle; it must not be taken there.
        tb_data = 20'h0;
        @(negedge clk);
        checks++; if ({m_ready, m_e, m_done} !== 3'b110) begin failures++; $display("FAIL b2b_gap got=%b exp=110", {m_ready, m_e, m_done}); end
        xfer(20'h00000, 1'b0, 0, bits, rises, done_at, bad, r0, pr, rb, rbv, cpd, dd, ed);
        checks++; if (r0 !== 1'b1) begin failures++; $display("FAIL b2b2_ready got=%b exp=1", r0); end
        checks++; if (bits !== 20'h0) begin failures++; $display("FAIL b2b2_bits got=%h exp=00000", bits); end
        checks++; if (rises !== 20) begin failures++; $display("FAIL b2b2_rises got=%0d exp=20", rises); end
        checks++; if (done_at !== 41) begin failures++; $display("FAIL b2b2_done_at got=%0d exp=41", done_at); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b2_protocol got=%0d exp=0", bad); end
        checks++; if (m_chain !== 20'h0) begin failures++; $display("FAIL b2b2_chain got=%h exp=00000", m_chain); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [19:0] bits, rb, word; int rises, done_at, bad, n_rise, n_done; logic r0, pr, rbv, cpd, dd, ed, prev_cp;
        sel  = 1'b0;
        word = 20'($urandom) & 20'h003FF;
        preload(20'h0);
        tb_data  = word;
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        for (int k = 1; k <= 15; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({a_sr_cp, a_sr_data, a_sr_e, a_done, a_rb_valid} !== 5'b0) begin failures++; $display("FAIL mid_outs got=%b exp=00000", {a_sr_cp, a_sr_data, a_sr_e, a_done, a_rb_valid}); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", a_in_ready); end
        checks++; if (a_rb_data !== 10'h0) begin failures++; $display("FAIL mid_rb got=%h exp=0", a_rb_data); end
        rst_n   = 1'b1;
        n_rise  = 0;
        n_done  = 0;
        prev_cp = a_sr_cp;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (a_sr_cp === 1'b1 && prev_cp !== 1'b1) n_rise++;
            if (a_done !== 1'b0) n_done++;
            prev_cp = a_sr_cp;
        end
        checks++; if (n_rise !== 0 || n_done !== 0) begin failures++; $display("FAIL mid_quiet got=rises:%0d/dones:%0d exp=0/0", n_rise, n_done); end
        $display("abort word=%05h rises_after=%0d dones_after=%0d", word, n_rise, n_done);
        word = 20'($urandom) & 20'h003FF;
        preload(20'h00155);
        xfer(word, 1'b0, 0, bits, rises, done_at, bad, r0, pr, rb, rbv, cpd, dd, ed);
        checks++; if (bits !== word) begin failures++; $display("FAIL mid_reload_bits got=%h exp=%h", bits, word); end
        checks++; if (done_at !== 41) begin failures++; $display("FAIL mid_reload_done_at got=%0d exp=41", done_at); end
        checks++; if (rb !== (RB_EN ? 20'h00155 : 20'h0)) begin failures++; $display("FAIL mid_reload_rb got=%h exp=%h", rb, RB_EN ? 20'h00155 : 20'h0); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignore_valid;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
